// File: rtl/execute_mdu_if.sv
// execute_mdu_if: issue/flush/stall inputs and EX/MA outputs of the
// iterative multiply/divide unit, bundled for the pipeline connection.
interface execute_mdu_if #(
    parameter int XLEN = 64
);
    logic            clear;
    logic            stall;
    logic            start;
    logic [2:0]      op;
    logic            word;
    logic [63:0]     pc;
    logic [4:0]      rd;
    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;
    logic            busy;
    logic [63:0]     pc_out;
    logic [4:0]      rd_out;
    logic [XLEN-1:0] result_out;
    logic            valid_out;

    modport master (
        output clear, stall, start, op, word, pc, rd, fwd1, fwd2,
        input  busy, pc_out, rd_out, result_out, valid_out
    );

    modport slave (
        input  clear, stall, start, op, word, pc, rd, fwd1, fwd2,
        output busy, pc_out, rd_out, result_out, valid_out
    );
endinterface

// File: rtl/execute_mdu.sv
// execute_mdu: iterative RV multiply/divide execute stage with EX/MA register.
// Shift-add multiplier and restoring divider on operand magnitudes, STEP_BITS
// bits retired per cycle, sign fixed up when the result is written.
// Optional feature: define MDU_EARLY_OUT_EN to finish trivial cases (zero
// multiplicand, |dividend| < |divisor|) after a single BUSY cycle.
//
// state  | meaning
// IDLE   | waiting for start; EX/MA register gets bubbles
// BUSY   | iterating, cnt_q counts down to terminal count 0
// DONE   | result ready, waiting for stall=0 to write EX/MA
module execute_mdu #(
    parameter int XLEN      = 64,
    parameter int STEP_BITS = 1,
    parameter int W_OPS     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    execute_mdu_if.slave bus
);
    localparam int N_FULL = XLEN / STEP_BITS;
    localparam int N_WORD = 32 / STEP_BITS;
    localparam int CNT_W  = $clog2(N_FULL + 1);
    localparam int WSH    = XLEN - 32;
    localparam bit W_EN   = (W_OPS != 0) && (XLEN == 64);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_DIVZ, SP_OVF, SP_EARLY} spec_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        return XLEN'($signed(x));
    endfunction

    state_t            state_q;
    spec_t             spec_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        op_q;
    logic              word_q, sa_q, sb_q;
    logic [63:0]       pc_q, pc_out_q;
    logic [4:0]        rd_q, rd_out_q;
    logic [XLEN-1:0]   ea_q, opnd_q, lo_q, result_q;
    logic [XLEN:0]     hi_q;
    logic              valid_q;

    logic              in_word, in_s1, in_s2, in_div, in_sa, in_sb, in_early;
    logic [XLEN-1:0]   in_ea, in_eb, in_ma, in_mb, most_neg;
    spec_t             in_spec;
    logic              accept;

    // Issue decode: operand extension, magnitudes and fast-path detection.
    always_comb begin
        in_word  = W_EN && bus.word;
        in_div   = bus.op[2];
        in_s1    = (bus.op != 3'd3) && (bus.op != 3'd5) && (bus.op != 3'd7);
        in_s2    = (bus.op == 3'd0) || (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
        in_ea    = bus.fwd1;
        in_eb    = bus.fwd2;
        if (in_word) begin
            in_ea = in_s1 ? sext32(bus.fwd1[31:0]) : XLEN'(bus.fwd1[31:0]);
            in_eb = in_s2 ? sext32(bus.fwd2[31:0]) : XLEN'(bus.fwd2[31:0]);
        end
        in_sa    = in_s1 && in_ea[XLEN-1];
        in_sb    = in_s2 && in_eb[XLEN-1];
        in_ma    = in_sa ? -in_ea : in_ea;
        in_mb    = in_sb ? -in_eb : in_eb;
        most_neg = in_word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
`ifdef MDU_EARLY_OUT_EN
        in_early = in_div ? (in_ma < in_mb) : ((in_ea == '0) || (in_eb == '0));
`else
        in_early = 1'b0;
`endif
        in_spec  = SP_NONE;
        if (in_div && (in_eb == '0))
            in_spec = SP_DIVZ;
        else if (in_div && in_s2 && (in_eb == '1) && (in_ea == most_neg))
            in_spec = SP_OVF;
        else if (in_early)
            in_spec = SP_EARLY;
    end

    // A new op is taken from IDLE, or straight out of DONE when it retires.
    assign accept = !bus.clear && bus.start &&
                    ((state_q == S_IDLE) || ((state_q == S_DONE) && !bus.stall));

    assign bus.busy = accept || (state_q == S_BUSY) || ((state_q == S_DONE) && bus.stall);

    logic [XLEN+STEP_BITS-1:0] mul_sum;
    logic [XLEN:0]             dv_r, hi_d;
    logic [XLEN-1:0]           dv_q, lo_d;

    // One iteration: STEP_BITS multiplier bits added in, or STEP_BITS restoring
    // divide steps (remainder in hi, dividend/quotient shifting through lo).
    always_comb begin
        mul_sum = (XLEN+STEP_BITS)'(hi_q[XLEN-1:0]) +
                  (XLEN+STEP_BITS)'(opnd_q) * (XLEN+STEP_BITS)'(lo_q[STEP_BITS-1:0]);
        dv_r = hi_q;
        dv_q = lo_q;
        for (int i = 0; i < STEP_BITS; i++) begin
            dv_r = {dv_r[XLEN-1:0], dv_q[XLEN-1]};
            dv_q = {dv_q[XLEN-2:0], 1'b0};
            if (dv_r >= {1'b0, opnd_q}) begin
                dv_r    = dv_r - {1'b0, opnd_q};
                dv_q[0] = 1'b1;
            end
        end
        if (op_q[2]) begin
            hi_d = dv_r;
            lo_d = dv_q;
        end else begin
            hi_d = {1'b0, mul_sum[XLEN+STEP_BITS-1:STEP_BITS]};
            lo_d = {mul_sum[STEP_BITS-1:0], lo_q[XLEN-1:STEP_BITS]};
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, res;

    // Final sign fix, op select, fast-path override and *W sign extension.
    always_comb begin
        prod = {hi_q[XLEN-1:0], lo_q};
        if (word_q)
            prod = prod >> WSH;
        if (sa_q ^ sb_q)
            prod = -prod;
        quo = (sa_q ^ sb_q) ? -lo_q : lo_q;
        rem = sa_q ? -hi_q[XLEN-1:0] : hi_q[XLEN-1:0];
        case (op_q)
            3'd0:                res = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    res = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:          res = quo;
            default:             res = rem;
        endcase
        case (spec_q)
            SP_DIVZ:  res = op_q[1] ? ea_q : '1;
            SP_OVF:   res = op_q[1] ? '0 : ea_q;
            SP_EARLY: res = (op_q[2] && op_q[1]) ? ea_q : '0;
            default:  ;
        endcase
        if (word_q)
            res = sext32(res[31:0]);
    end

    // FSM, iteration datapath and EX/MA register; clear beats stall and start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            spec_q   <= SP_NONE;
            cnt_q    <= '0;
            op_q     <= '0;
            word_q   <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            pc_q     <= '0;
            rd_q     <= '0;
            ea_q     <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            pc_out_q <= '0;
            rd_out_q <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else if (bus.clear) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            pc_out_q <= '0;
            rd_out_q <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (!bus.stall) begin
                valid_q  <= 1'b0;
                rd_out_q <= '0;
            end
            if (state_q == S_BUSY) begin
                hi_q <= hi_d;
                lo_q <= lo_d;
                if (cnt_q == '0)
                    state_q <= S_DONE;
                else
                    cnt_q <= cnt_q - CNT_W'(1);
            end
            if ((state_q == S_DONE) && !bus.stall) begin
                pc_out_q <= pc_q;
                rd_out_q <= rd_q;
                result_q <= res;
                valid_q  <= 1'b1;
                state_q  <= S_IDLE;
            end
            if (accept) begin
                state_q <= S_BUSY;
                op_q    <= bus.op;
                word_q  <= in_word;
                pc_q    <= bus.pc;
                rd_q    <= bus.rd;
                sa_q    <= in_sa;
                sb_q    <= in_sb;
                ea_q    <= in_ea;
                spec_q  <= in_spec;
                opnd_q  <= in_div ? in_mb : in_ma;
                hi_q    <= '0;
                lo_q    <= in_div ? (in_word ? (in_ma << WSH) : in_ma) : in_mb;
                if (in_spec != SP_NONE)
                    cnt_q <= '0;
                else if (in_word)
                    cnt_q <= CNT_W'(N_WORD - 1);
                else
                    cnt_q <= CNT_W'(N_FULL - 1);
            end
        end
    end

    assign bus.pc_out     = pc_out_q;
    assign bus.rd_out     = rd_out_q;
    assign bus.result_out = result_q;
    assign bus.valid_out  = valid_q;
endmodule

// File: tb/tb_execute_mdu.sv
module tb_execute_mdu;
    localparam int XLEN = 64;
    localparam int STEP = 1;
    localparam int NF   = 64 / STEP;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    execute_mdu_if #(.XLEN(XLEN)) bus ();
    execute_mdu #(.XLEN(XLEN), .STEP_BITS(STEP), .W_OPS(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result from RISC-V M-extension arithmetic rules.
    function automatic logic [63:0] ref_res(input logic [2:0] op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] xa, xb, p;
        logic [31:0] ua, ub, r32;
        int          s32a, s32b;
        longint      s64a, s64b;
        logic [63:0] r64;
        r64 = '0;
        if (w) begin
            ua = a[31:0]; ub = b[31:0];
            s32a = ua; s32b = ub;
            r32 = '0;
            case (op)
                3'd4: if (ub == 0) r32 = '1;
                      else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r32 = ua;
                      else r32 = s32a / s32b;
                3'd5: r32 = (ub == 0) ? 32'hFFFF_FFFF : ua / ub;
                3'd6: if (ub == 0) r32 = ua;
                      else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r32 = 0;
                      else r32 = s32a % s32b;
                3'd7: r32 = (ub == 0) ? ua : ua % ub;
                default: r32 = ua * ub;
            endcase
            return {{32{r32[31]}}, r32};
        end
        s64a = a; s64b = b;
        case (op)
            3'd0: r64 = a * b;
            3'd1: begin xa = $signed(a); xb = $signed(b); p = xa * xb; r64 = p[127:64]; end
            3'd2: begin xa = $signed(a); xb = {64'd0, b}; p = xa * xb; r64 = p[127:64]; end
            3'd3: begin xa = {64'd0, a}; xb = {64'd0, b}; p = xa * xb; r64 = p[127:64]; end
            3'd4: if (b == 0) r64 = '1;
                  else if (a == 64'h8000_0000_0000_0000 && b == '1) r64 = a;
                  else r64 = s64a / s64b;
            3'd5: r64 = (b == 0) ? '1 : a / b;
            3'd6: if (b == 0) r64 = a;
                  else if (a == 64'h8000_0000_0000_0000 && b == '1) r64 = 0;
                  else r64 = s64a % s64b;
            default: r64 = (b == 0) ? a : a % b;
        endcase
        return r64;
    endfunction

    // Reference start-to-valid latency (cycles) with stall held low.
    function automatic int ref_lat(input logic [2:0] op, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        logic [63:0] ea, eb;
        bit sg1, sg2;
        sg1 = !(op == 3 || op == 5 || op == 7);
        sg2 = (op == 0 || op == 1 || op == 4 || op == 6);
        ea = a; eb = b;
        if (w) begin
            ea = sg1 ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
            eb = sg2 ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
        end
        if (op[2]) begin
            if (eb == 0) return 3;
            if (sg2 && eb == '1 && ea == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000))
                return 3;
        end
`ifdef MDU_EARLY_OUT_EN
        begin
            logic [63:0] ma, mb;
            ma = (sg1 && ea[63]) ? -ea : ea;
            mb = (sg2 && eb[63]) ? -eb : eb;
            if (op[2] ? (ma < mb) : (ea == 0 || eb == 0)) return 3;
        end
`endif
        return (w ? 32 : 64) / STEP + 2;
    endfunction

    task automatic do_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int exp_lat,
                         input string tag);
        int lat, fall;
        logic [4:0]  rd;
        logic [63:0] pc;
        rd = 5'($urandom_range(1, 31));
        pc = {$urandom, $urandom};
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.word = w;
        bus.fwd1 = a; bus.fwd2 = b; bus.rd = rd; bus.pc = pc;
        #1 chk({tag, "/busy_on_start"}, 64'(bus.busy), 64'd1);
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'($urandom); bus.word = 1'($urandom);
        bus.fwd1 = {$urandom, $urandom}; bus.fwd2 = {$urandom, $urandom};
        bus.rd = 5'($urandom); bus.pc = {$urandom, $urandom};
        lat = 1; fall = 0;
        while (!bus.valid_out && lat < 300) begin
            if (!bus.busy && fall == 0) fall = lat;
            @(negedge clk);
            lat++;
        end
        chk({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "/busy_fall"}, 64'(fall), 64'(exp_lat - 1));
        chk({tag, "/result"}, bus.result_out, exp);
        chk({tag, "/rd_out"}, 64'(bus.rd_out), 64'(rd));
        chk({tag, "/pc_out"}, bus.pc_out, pc);
        @(negedge clk);
        chk({tag, "/bubble_valid"}, 64'(bus.valid_out), 64'd0);
        chk({tag, "/bubble_rd"}, 64'(bus.rd_out), 64'd0);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'($urandom_range(0, 20));
            4: return -64'($urandom_range(1, 20));
            5: return {32'($urandom), 32'h8000_0000};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vt[16];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt, lat;
        logic [2:0]  op;
        logic        w;
        logic [63:0] a, b;

        vt[0]  = '{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, NF + 2};
        vt[1]  = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, NF + 2};
        vt[2]  = '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, NF + 2};
        vt[3]  = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, NF + 2};
        vt[4]  = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, NF + 2};
        vt[5]  = '{3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3};
        vt[6]  = '{3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 3};
        vt[7]  = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 3};
        vt[8]  = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 3};
        vt[9]  = '{3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 3};
        vt[10] = '{3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32 / STEP + 2};
        vt[11] = '{3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, NF + 2};
        vt[12] = '{3'd7, 1'b1, 64'h1234_5678_0000_0007, 64'h9999_9999_0000_0003, 64'd1, 32 / STEP + 2};
        vt[13] = '{3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32 / STEP + 2};
        vt[14] = '{3'd3, 1'b0, 64'h10, 64'h1000_0000_0000_0000, 64'd1, NF + 2};
        vt[15] = '{3'd7, 1'b0, 64'd100, 64'd7, 64'd2, NF + 2};

        bus.clear = 0; bus.stall = 0; bus.start = 0; bus.op = 0; bus.word = 0;
        bus.pc = 0; bus.rd = 0; bus.fwd1 = 0; bus.fwd2 = 0;
        repeat (3) @(negedge clk);
        chk("reset/busy", 64'(bus.busy), 64'd0);
        chk("reset/valid", 64'(bus.valid_out), 64'd0);
        chk("reset/result", bus.result_out, 64'd0);
        chk("reset/rd", 64'(bus.rd_out), 64'd0);
        chk("reset/pc", bus.pc_out, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++)
            do_op(vt[i].op, vt[i].w, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat, $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            if (w && (op == 1 || op == 2 || op == 3)) op = 3'd0;
            a = pick(); b = pick();
            do_op(op, w, a, b, ref_res(op, w, a, b), ref_lat(op, w, a, b), $sformatf("rnd%0d", i));
        end

        // Stall held in DONE: busy stays up, EX/MA keeps the older result.
        do_op(3'd0, 1'b0, 64'd3, 64'd5, 64'd15, NF + 2, "stall_pre");
        @(negedge clk);
        bus.stall = 1'b1; bus.start = 1'b1; bus.op = 3'd5; bus.word = 1'b0;
        bus.fwd1 = 64'd100; bus.fwd2 = 64'd7; bus.rd = 5'd9; bus.pc = 64'h40;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (NF) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall/busy_held", 64'(bus.busy), 64'd1);
            chk("stall/result_held", bus.result_out, 64'd15);
            @(negedge clk);
        end
        bus.stall = 1'b0;
        #1 chk("stall/busy_release", 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("stall/valid", 64'(bus.valid_out), 64'd1);
        chk("stall/result", bus.result_out, 64'd14);
        chk("stall/rd", 64'(bus.rd_out), 64'd9);

        // Start held while busy must not replace the op in flight.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.fwd1 = 64'd6; bus.fwd2 = 64'd7; bus.rd = 5'd3;
        @(negedge clk);
        bus.op = 3'd5; bus.fwd1 = 64'd100; bus.fwd2 = 64'd3; bus.rd = 5'd4;
        lat = 1;
        repeat (20) begin @(negedge clk); lat++; end
        bus.start = 1'b0;
        while (!bus.valid_out && lat < 300) begin @(negedge clk); lat++; end
        chk("ignore/latency", 64'(lat), 64'(NF + 2));
        chk("ignore/result", bus.result_out, 64'd42);
        chk("ignore/rd", 64'(bus.rd_out), 64'd3);
        @(negedge clk);
        chk("ignore/idle_busy", 64'(bus.busy), 64'd0);

        // Clear in BUSY cycle 10 aborts the op and zeroes EX/MA.
        bus.start = 1'b1; bus.op = 3'd0; bus.fwd1 = 64'd9; bus.fwd2 = 64'd9; bus.rd = 5'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        chk("clear/busy", 64'(bus.busy), 64'd0);
        chk("clear/valid", 64'(bus.valid_out), 64'd0);
        chk("clear/rd", 64'(bus.rd_out), 64'd0);
        chk("clear/result", bus.result_out, 64'd0);
        cnt = 0;
        repeat (NF + 10) begin @(negedge clk); if (bus.valid_out) cnt++; end
        chk("clear/no_late_result", 64'(cnt), 64'd0);

        // Asynchronous reset mid-operation discards the op.
        do_op(3'd0, 1'b0, 64'd11, 64'd11, 64'd121, NF + 2, "rst_pre");
        bus.start = 1'b1; bus.op = 3'd5; bus.fwd1 = 64'd1000; bus.fwd2 = 64'd10; bus.rd = 5'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid/busy", 64'(bus.busy), 64'd0);
        chk("rst_mid/result", bus.result_out, 64'd0);
        chk("rst_mid/pc", bus.pc_out, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (NF + 10) begin @(negedge clk); if (bus.valid_out || bus.busy) cnt++; end
        chk("rst_mid/no_result", 64'(cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
